cluster_sbit_expander: RTL



---
 rtl/cluster_sbit_expander_if.sv | 54 +++++
 rtl/cluster_sbit_expander.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cluster_sbit_expander_if.sv
// Bundles the cluster expander's data-path signals.
// The cluster stream and frame strobe travel from source to expander.
// The reconstructed maps and frame status travel from expander to consumer.
//
// Modports:
//   master - the cluster source and frame consumer. It drives the cluster fields
//            and bx_strobe, and it receives the maps and status.
//   slave  - the expander itself.
//
// Signals:
//   cluster_valid   cluster fields are valid this cycle
//   cluster_adr     key address within the partition
//   cluster_prt     partition index
//   cluster_cnt     number of consecutive pads after the primary
//   bx_strobe       closes the current frame; a cluster presented in the
//                   same cycle belongs to the closing frame
//   sbits_out       reconstructed S-bit map of the last closed frame
//   vpfs_out        primary-pad flags of the last closed frame
//   sbits_valid     one-cycle pulse when the maps and status update
//   cluster_count   clusters accepted in the last closed frame
//   frame_overflow  last closed frame had more valid clusters than the limit
//   adr_error       last closed frame contained an out-of-range cluster
interface cluster_sbit_expander_if #(
    parameter int MXPADS    = 1536,
    parameter int MXADRBITS = 8,
    parameter int MXPRTBITS = 3,
    parameter int MXCNTBITS = 3,
    parameter int CCNTBITS  = 5
);
    logic                 cluster_valid;
    logic [MXADRBITS-1:0] cluster_adr;
    logic [MXPRTBITS-1:0] cluster_prt;
    logic [MXCNTBITS-1:0] cluster_cnt;
    logic                 bx_strobe;

    logic [MXPADS-1:0]    sbits_out;
    logic [MXPADS-1:0]    vpfs_out;
    logic                 sbits_valid;
    logic [CCNTBITS-1:0]  cluster_count;
    logic                 frame_overflow;
    logic                 adr_error;

    modport master (
        output cluster_valid, cluster_adr, cluster_prt, cluster_cnt, bx_strobe,
        input  sbits_out, vpfs_out, sbits_valid, cluster_count,
               frame_overflow, adr_error
    );

    modport slave (
        input  cluster_valid, cluster_adr, cluster_prt, cluster_cnt, bx_strobe,
        output sbits_out, vpfs_out, sbits_valid, cluster_count,
               frame_overflow, adr_error
    );
endinterface

// File: rtl/cluster_sbit_expander.sv
// Cluster S-bit expander: this block undoes the cluster-primary finder.
// Clusters arrive serially, one per cycle, each as (partition, key address,
// size count). They are expanded back into a full MXPADS-wide S-bit map and a
// matching primary-flag (vpf) map. Each bx_strobe closes a frame. Two cycles
// after the strobe, the frame's maps and status appear on the outputs.
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset
//   bus    cluster_sbit_expander_if.slave (cluster stream in; maps and status out)
//
// Pipeline:
//   input  - Range-checks the cluster and applies the per-frame acceptance
//            limit. It also tracks the frame's count and error flags.
//   stage1 - Registers the partition-wide span mask, the one-hot primary, the
//            partition index and the frame-close tag. When the tag is set, it
//            also registers the closing frame's status.
//   stage2 - ORs stage1 into the full-width accumulators. When the close tag
//            is set, it transfers the accumulators to the outputs and clears them.
module cluster_sbit_expander #(
    parameter int MXPADS     = 1536,
    parameter int MXROWS     = 8,
    parameter int MXKEYS     = 192,
    parameter int MXADRBITS  = 8,
    parameter int MXPRTBITS  = 3,
    parameter int MXCNTBITS  = 3,
    parameter int MXCLUSTERS = 16,
    parameter int CCNTBITS   = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    cluster_sbit_expander_if.slave  bus
);

    // One extra bit so adr+cnt cannot wrap before the span compare.
    localparam int SPANW = MXADRBITS + 1;

    // ------------------------------------------------------------------
    // Input side: range check, acceptance limit, per-frame statistics
    // ------------------------------------------------------------------
    logic                in_bad;
    logic                in_accept;
    logic                in_over;

    logic [CCNTBITS-1:0] fcnt_q, fcnt_d;
    logic                fovf_q, fovf_d;
    logic                faerr_q, faerr_d;

    always_comb begin
        in_bad    = (int'(bus.cluster_adr) >= MXKEYS) ||
                    (int'(bus.cluster_prt) >= MXROWS);
        // A dropped out-of-range cluster never consumes an acceptance slot.
        in_accept = bus.cluster_valid && !in_bad &&
                    (fcnt_q <  CCNTBITS'(MXCLUSTERS));
        in_over   = bus.cluster_valid && !in_bad &&
                    (fcnt_q >= CCNTBITS'(MXCLUSTERS));
        fcnt_d    = fcnt_q + CCNTBITS'(in_accept);
        fovf_d    = fovf_q  | in_over;
        faerr_d   = faerr_q | (bus.cluster_valid & in_bad);
    end

    // ------------------------------------------------------------------
    // Span and primary decode within one partition
    // ------------------------------------------------------------------
    logic [SPANW-1:0]  span_lo;
    logic [SPANW-1:0]  span_hi;
    logic [MXKEYS-1:0] mask_d;
    logic [MXKEYS-1:0] vpf_d;

    always_comb begin
        span_lo = SPANW'(bus.cluster_adr);
        span_hi = span_lo + SPANW'(bus.cluster_cnt);
        mask_d  = '0;
        vpf_d   = '0;
        // Keys past MXKEYS-1 do not exist in the mask.
        // A cluster at the partition edge is truncated and never reaches partition prt+1.
        for (int k = 0; k < MXKEYS; k++) begin
            mask_d[k] = (SPANW'(k) >= span_lo) && (SPANW'(k) <= span_hi);
            vpf_d[k]  = (SPANW'(k) == span_lo);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic                 s1_valid_q;
    logic                 s1_close_q;
    logic [MXPRTBITS-1:0] s1_prt_q;
    logic [MXKEYS-1:0]    s1_mask_q;
    logic [MXKEYS-1:0]    s1_vpf_q;
    logic [CCNTBITS-1:0]  s1_cnt_q;
    logic                 s1_ovf_q;
    logic                 s1_aerr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_close_q <= 1'b0;
            s1_prt_q   <= '0;
            s1_mask_q  <= '0;
            s1_vpf_q   <= '0;
            s1_cnt_q   <= '0;
            s1_ovf_q   <= 1'b0;
            s1_aerr_q  <= 1'b0;
            fcnt_q     <= '0;
            fovf_q     <= 1'b0;
            faerr_q    <= 1'b0;
        end else begin
            s1_valid_q <= in_accept;
            s1_close_q <= bus.bx_strobe;
            s1_prt_q   <= bus.cluster_prt;
            s1_mask_q  <= mask_d;
            s1_vpf_q   <= vpf_d;
            if (bus.bx_strobe) begin
                // The closing frame's status includes this cycle's cluster.
                // The counters then restart for the next frame.
                s1_cnt_q  <= fcnt_d;
                s1_ovf_q  <= fovf_d;
                s1_aerr_q <= faerr_d;
                fcnt_q    <= '0;
                fovf_q    <= 1'b0;
                faerr_q   <= 1'b0;
            end else begin
                fcnt_q    <= fcnt_d;
                fovf_q    <= fovf_d;
                faerr_q   <= faerr_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: place the partition mask and accumulate
    // ------------------------------------------------------------------
    logic [MXPADS-1:0] placed_sbits;
    logic [MXPADS-1:0] placed_vpfs;
    logic [MXPADS-1:0] acc_sbits_q, acc_sbits_d;
    logic [MXPADS-1:0] acc_vpfs_q,  acc_vpfs_d;

    always_comb begin
        placed_sbits = '0;
        placed_vpfs  = '0;
        for (int r = 0; r < MXROWS; r++) begin
            if (s1_valid_q && (int'(s1_prt_q) == r)) begin
                placed_sbits[r*MXKEYS +: MXKEYS] = s1_mask_q;
                placed_vpfs[r*MXKEYS +: MXKEYS]  = s1_vpf_q;
            end
        end
        acc_sbits_d = acc_sbits_q | placed_sbits;
        acc_vpfs_d  = acc_vpfs_q  | placed_vpfs;
    end

    logic [MXPADS-1:0]   sbits_out_q;
    logic [MXPADS-1:0]   vpfs_out_q;
    logic                sbits_valid_q;
    logic [CCNTBITS-1:0] cluster_count_q;
    logic                frame_overflow_q;
    logic                adr_error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_sbits_q      <= '0;
            acc_vpfs_q       <= '0;
            sbits_out_q      <= '0;
            vpfs_out_q       <= '0;
            sbits_valid_q    <= 1'b0;
            cluster_count_q  <= '0;
            frame_overflow_q <= 1'b0;
            adr_error_q      <= 1'b0;
        end else begin
            sbits_valid_q <= s1_close_q;
            if (s1_close_q) begin
                // Transfer and clear in the same cycle.
                // The next frame's first cluster can follow immediately.
                sbits_out_q      <= acc_sbits_d;
                vpfs_out_q       <= acc_vpfs_d;
                cluster_count_q  <= s1_cnt_q;
                frame_overflow_q <= s1_ovf_q;
                adr_error_q      <= s1_aerr_q;
                acc_sbits_q      <= '0;
                acc_vpfs_q       <= '0;
            end else begin
                acc_sbits_q      <= acc_sbits_d;
                acc_vpfs_q       <= acc_vpfs_d;
            end
        end
    end

    assign bus.sbits_out      = sbits_out_q;
    assign bus.vpfs_out       = vpfs_out_q;
    assign bus.sbits_valid    = sbits_valid_q;
    assign bus.cluster_count  = cluster_count_q;
    assign bus.frame_overflow = frame_overflow_q;
    assign bus.adr_error      = adr_error_q;

endmodule
